// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle control FSM and the datapath:
// the opcode and memory handshake come in, the mux selects and write enables go out.
interface mc_control_fsm_if #(
    parameter int OPW = 6
);
  logic [OPW-1:0] op;
  logic           mem_ready;
  logic           iord;
  logic           irwrite;
  logic           memread;
  logic           memwrite;
  logic           pcwrite;
  logic           branch;
  logic           branch_ne;
  logic           regwrite;
  logic [1:0]     regdst;
  logic [1:0]     memtoreg;
  logic           alusrca;
  logic [1:0]     alusrcb;
  logic [2:0]     aluop;
  logic [1:0]     pcsrc;
  logic           illegal_op;
  logic           instr_done;
  logic [4:0]     state;

  modport master (
    input  op, mem_ready,
    output iord, irwrite, memread, memwrite, pcwrite, branch, branch_ne, regwrite,
           regdst, memtoreg, alusrca, alusrcb, aluop, pcsrc, illegal_op, instr_done, state
  );

  modport slave (
    output op, mem_ready,
    input  iord, irwrite, memread, memwrite, pcwrite, branch, branch_ne, regwrite,
           regdst, memtoreg, alusrca, alusrcb, aluop, pcsrc, illegal_op, instr_done, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit with memory wait states, extended ISA decode,
// sticky illegal-opcode trap and debug/retire outputs.
module mc_control_fsm #(
  parameter int OPW         = 6,
  parameter int ENABLE_WAIT = 1,
  parameter int ENABLE_EXT  = 1
) (
  input  logic            clk,
  input  logic            reset,
  mc_control_fsm_if.master bus
);

  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,  S_DECODE = 5'd1,  S_MEMADR = 5'd2,  S_MEMRD  = 5'd3,
    S_MEMWB  = 5'd4,  S_MEMWR  = 5'd5,  S_RTEX   = 5'd6,  S_RTWB   = 5'd7,
    S_BEQ    = 5'd8,  S_ADDIEX = 5'd9,  S_IWB    = 5'd10, S_JUMP   = 5'd11,
    S_BNE    = 5'd12, S_ANDIEX = 5'd13, S_ORIEX  = 5'd14, S_SLTIEX = 5'd15,
    S_JAL    = 5'd16, S_TRAP   = 5'd17
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001010);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b000011);

  localparam bit EXT_ON = (ENABLE_EXT != 0);

  function automatic state_t decode_op(input logic [OPW-1:0] o);
    state_t d;
    if (o == OP_RTYPE)                  d = S_RTEX;
    else if (o == OP_LW || o == OP_SW)  d = S_MEMADR;
    else if (o == OP_BEQ)               d = S_BEQ;
    else if (o == OP_ADDI)              d = S_ADDIEX;
    else if (o == OP_J)                 d = S_JUMP;
    else if (EXT_ON && o == OP_BNE)     d = S_BNE;
    else if (EXT_ON && o == OP_ANDI)    d = S_ANDIEX;
    else if (EXT_ON && o == OP_ORI)     d = S_ORIEX;
    else if (EXT_ON && o == OP_SLTI)    d = S_SLTIEX;
    else if (EXT_ON && o == OP_JAL)     d = S_JAL;
    else                                d = S_TRAP;
    return d;
  endfunction

  state_t state_r;
  state_t dec_s;
  logic   illegal_r;
  logic   ready_s;

  logic       iord_s, irwrite_s, memread_s, memwrite_s, pcwrite_s;
  logic       branch_s, branch_ne_s, regwrite_s, alusrca_s, instr_done_s;
  logic [1:0] regdst_s, memtoreg_s, alusrcb_s, pcsrc_s;
  logic [2:0] aluop_s;

  assign ready_s = (ENABLE_WAIT != 0) ? bus.mem_ready : 1'b1;
  assign dec_s   = decode_op(bus.op);

  // State register and sticky illegal-opcode flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= S_FETCH;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        S_FETCH:  state_r <= ready_s ? S_DECODE : S_FETCH;
        S_DECODE: begin
          state_r   <= dec_s;
          illegal_r <= illegal_r | (dec_s == S_TRAP);
        end
        S_MEMADR: state_r <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state_r <= ready_s ? S_MEMWB : S_MEMRD;
        S_MEMWR:  state_r <= ready_s ? S_FETCH : S_MEMWR;
        S_RTEX:   state_r <= S_RTWB;
        S_ADDIEX, S_ANDIEX, S_ORIEX, S_SLTIEX: state_r <= S_IWB;
        S_TRAP: begin
          state_r   <= S_FETCH;
          illegal_r <= 1'b1;
        end
        // Single-cycle finishing states and unused encodings all return to FETCH
        default:  state_r <= S_FETCH;
      endcase
    end
  end

  // Per-state control decode; everything not named for a state stays 0
  always_comb begin
    iord_s       = 1'b0;
    irwrite_s    = 1'b0;
    memread_s    = 1'b0;
    memwrite_s   = 1'b0;
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;
    branch_ne_s  = 1'b0;
    regwrite_s   = 1'b0;
    alusrca_s    = 1'b0;
    instr_done_s = 1'b0;
    regdst_s     = 2'b00;
    memtoreg_s   = 2'b00;
    alusrcb_s    = 2'b00;
    pcsrc_s      = 2'b00;
    aluop_s      = 3'b000;
    case (state_r)
      S_FETCH: begin
        memread_s = 1'b1;
        alusrcb_s = 2'b01;
        irwrite_s = ready_s;
        pcwrite_s = ready_s;
      end
      S_DECODE: alusrcb_s = 2'b11;
      S_MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      S_MEMRD: begin
        iord_s    = 1'b1;
        memread_s = 1'b1;
      end
      S_MEMWB: begin
        memtoreg_s   = 2'b01;
        regwrite_s   = 1'b1;
        instr_done_s = 1'b1;
      end
      S_MEMWR: begin
        iord_s       = 1'b1;
        memwrite_s   = 1'b1;
        instr_done_s = ready_s;
      end
      S_RTEX: begin
        alusrca_s = 1'b1;
        aluop_s   = 3'b010;
      end
      S_RTWB: begin
        regdst_s     = 2'b01;
        regwrite_s   = 1'b1;
        instr_done_s = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alusrca_s    = 1'b1;
        aluop_s      = 3'b001;
        pcsrc_s      = 2'b01;
        branch_s     = (state_r == S_BEQ);
        branch_ne_s  = (state_r == S_BNE);
        instr_done_s = 1'b1;
      end
      S_ADDIEX, S_ANDIEX, S_ORIEX, S_SLTIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        if (state_r == S_ANDIEX)      aluop_s = 3'b011;
        else if (state_r == S_ORIEX)  aluop_s = 3'b100;
        else if (state_r == S_SLTIEX) aluop_s = 3'b101;
        else                          aluop_s = 3'b000;
      end
      S_IWB: begin
        regwrite_s   = 1'b1;
        instr_done_s = 1'b1;
      end
      S_JUMP: begin
        pcsrc_s      = 2'b10;
        pcwrite_s    = 1'b1;
        instr_done_s = 1'b1;
      end
      // Link write uses memtoreg=PC, which still holds PC+4 during this cycle
      S_JAL: begin
        pcsrc_s      = 2'b10;
        pcwrite_s    = 1'b1;
        regdst_s     = 2'b10;
        memtoreg_s   = 2'b10;
        regwrite_s   = 1'b1;
        instr_done_s = 1'b1;
      end
      S_TRAP: begin
        pcsrc_s      = 2'b11;
        pcwrite_s    = 1'b1;
        instr_done_s = 1'b1;
      end
      default: iord_s = 1'b0;
    endcase
  end

  // Strobes and enables are held off for as long as reset is asserted
  assign bus.iord       = iord_s;
  assign bus.irwrite    = irwrite_s    & reset;
  assign bus.memread    = memread_s    & reset;
  assign bus.memwrite   = memwrite_s   & reset;
  assign bus.pcwrite    = pcwrite_s    & reset;
  assign bus.branch     = branch_s     & reset;
  assign bus.branch_ne  = branch_ne_s  & reset;
  assign bus.regwrite   = regwrite_s   & reset;
  assign bus.instr_done = instr_done_s & reset;
  assign bus.regdst     = regdst_s;
  assign bus.memtoreg   = memtoreg_s;
  assign bus.alusrca    = alusrca_s;
  assign bus.alusrcb    = alusrcb_s;
  assign bus.aluop      = aluop_s;
  assign bus.pcsrc      = pcsrc_s;
  assign bus.illegal_op = illegal_r;
  assign bus.state      = state_r;

endmodule
